// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory responder: default widths,
// responder FSM state type and statistics counter sizing.
package mem_pkg;

    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEFAULT_DATA_W = 3;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_t;

    // Saturating increment used by the statistics counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/mem_bank.sv
// Register-array backing store: synchronous write, asynchronous read, and a
// reset that reloads every word with the low bits of its own address.
module mem_bank
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] words;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            localparam logic [ADDR_W-1:0] WORD_ADDR = ADDR_W'(gi);
            localparam logic [DATA_W-1:0] INIT_VAL  = DATA_W'(gi);

            logic [DATA_W-1:0] word_reg;

            always_ff @(posedge clk) begin
                if (srst) begin
                    word_reg <= INIT_VAL;
                end else if (wr_en && (wr_addr == WORD_ADDR)) begin
                    word_reg <= wr_data;
                end
            end

            assign words[gi] = word_reg;
        end
    endgenerate

    assign rd_data = words[rd_addr];

endmodule

// File: rtl/main_memory_responder.sv
// Main memory responder: one outstanding fill/writeback request, fixed latency,
// single-cycle response pulse. Optional statistics via MAIN_MEM_STATS_EN.
module main_memory_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam logic [3:0] LAT_M1       = 4'(LATENCY - 1);
    localparam bit         SINGLE_CYCLE = (LATENCY == 1);

    resp_state_t       state_reg;
    logic [3:0]        count_reg;
    logic              write_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              req_ready_reg;
    logic              resp_valid_reg;
    logic [DATA_W-1:0] resp_rdata_reg;

    logic              accept;
    logic              enter_resp;
    logic              cur_write;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [DATA_W-1:0] mem_rdata;

    assign accept     = (state_reg == IDLE) && req_valid;
    assign enter_resp = (accept && SINGLE_CYCLE) ||
                        ((state_reg == WAIT) && (count_reg == 4'd1));

    // With a one-cycle latency the response is formed on the acceptance edge,
    // so the live request fields must be used instead of the latched copy.
    assign cur_write = (state_reg == IDLE) ? req_write : write_reg;
    assign cur_addr  = (state_reg == IDLE) ? req_addr  : addr_reg;
    assign cur_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;

    mem_bank #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_bank (
        .clk     (clock),
        .srst    (reset),
        .wr_en   (enter_resp && cur_write),
        .wr_addr (cur_addr),
        .wr_data (cur_wdata),
        .rd_addr (cur_addr),
        .rd_data (mem_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            count_reg      <= 4'd0;
            write_reg      <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            req_ready_reg  <= 1'b1;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
        end else begin
            resp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        write_reg     <= req_write;
                        addr_reg      <= req_addr;
                        wdata_reg     <= req_wdata;
                        count_reg     <= LAT_M1;
                        req_ready_reg <= 1'b0;
                        if (SINGLE_CYCLE) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (count_reg == 4'd1) begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                    end else begin
                        count_reg <= count_reg - 4'd1;
                    end
                end
                RESP: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                end
                default: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                end
            endcase
            if (enter_resp) begin
                resp_rdata_reg <= cur_write ? cur_wdata : mem_rdata;
            end
        end
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;

`ifdef MAIN_MEM_STATS_EN
    logic [CNT_W-1:0] rd_count_reg;
    logic [CNT_W-1:0] wr_count_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_count_reg <= '0;
            wr_count_reg <= '0;
        end else if (accept) begin
            if (req_write) begin
                wr_count_reg <= sat_inc(wr_count_reg);
            end else begin
                rd_count_reg <= sat_inc(rd_count_reg);
            end
        end
    end

    assign rd_count = rd_count_reg;
    assign wr_count = wr_count_reg;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_main_memory_responder.sv
// Randomized self-checking bench for main_memory_responder: two instances
// (LATENCY 2 and 1) checked against an array/count reference model.
module tb_main_memory_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       a_req_valid = 1'b0, a_req_write = 1'b0;
    logic [4:0] a_req_addr = '0;
    logic [2:0] a_req_wdata = '0;
    logic       a_req_ready, a_resp_valid;
    logic [2:0] a_resp_rdata;
    logic [7:0] a_rd_count, a_wr_count;

    logic       b_req_valid = 1'b0, b_req_write = 1'b0;
    logic [4:0] b_req_addr = '0;
    logic [2:0] b_req_wdata = '0;
    logic       b_req_ready, b_resp_valid;
    logic [2:0] b_resp_rdata;
    logic [7:0] b_rd_count, b_wr_count;

    int checks = 0;
    int failures = 0;

    logic [2:0] ref_mem [2][32];
    int         ref_rd [2];
    int         ref_wr [2];

    always #5 clk = ~clk;

    main_memory_responder #(.ADDR_W(5), .DATA_W(3), .LATENCY(2)) dut_a (
        .clock      (clk),
        .reset      (reset),
        .req_valid  (a_req_valid),
        .req_ready  (a_req_ready),
        .req_write  (a_req_write),
        .req_addr   (a_req_addr),
        .req_wdata  (a_req_wdata),
        .resp_valid (a_resp_valid),
        .resp_rdata (a_resp_rdata),
        .rd_count   (a_rd_count),
        .wr_count   (a_wr_count)
    );

    main_memory_responder #(.ADDR_W(5), .DATA_W(3), .LATENCY(1)) dut_b (
        .clock      (clk),
        .reset      (reset),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_write  (b_req_write),
        .req_addr   (b_req_addr),
        .req_wdata  (b_req_wdata),
        .resp_valid (b_resp_valid),
        .resp_rdata (b_resp_rdata),
        .rd_count   (b_rd_count),
        .wr_count   (b_wr_count)
    );

    function automatic logic [7:0] exp_cnt(input int n);
`ifdef MAIN_MEM_STATS_EN
        return (n > 255) ? 8'd255 : 8'(n);
`else
        return 8'd0;
`endif
    endfunction

    function automatic int lat_of(input int sel);
        return (sel == 0) ? 2 : 1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 32; a++) ref_mem[d][a] = 3'(a);
            ref_rd[d] = 0;
            ref_wr[d] = 0;
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic w,
                         input logic [4:0] addr, input logic [2:0] wdata);
        if (sel == 0) begin
            a_req_valid = v; a_req_write = w; a_req_addr = addr; a_req_wdata = wdata;
        end else begin
            b_req_valid = v; b_req_write = w; b_req_addr = addr; b_req_wdata = wdata;
        end
    endtask

    task automatic sample(input int sel, output logic rv, output logic rr,
                          output logic [2:0] rd, output logic [7:0] rc, output logic [7:0] wc);
        if (sel == 0) begin
            rv = a_resp_valid; rr = a_req_ready; rd = a_resp_rdata; rc = a_rd_count; wc = a_wr_count;
        end else begin
            rv = b_resp_valid; rr = b_req_ready; rd = b_resp_rdata; rc = b_rd_count; wc = b_wr_count;
        end
    endtask

    // Issue one request (caller is at a negedge with the DUT idle) and follow it
    // until req_ready returns; ends at the negedge of that cycle.
    task automatic txn(input int sel, input logic wr, input logic [4:0] addr,
                       input logic [2:0] wdata, input bit hold, input string tag);
        int         lat;
        logic       rv, rr;
        logic [2:0] rd, exp_data;
        logic [7:0] rc, wc;
        lat = lat_of(sel);
        drive(sel, 1'b1, wr, addr, wdata);
        sample(sel, rv, rr, rd, rc, wc);
        checks++;
        if (rr !== 1'b1) $display("FAIL %s ready_at_issue got=%b exp=1", tag, rr);
        if (wr) begin
            ref_mem[sel][addr] = wdata;
            exp_data = wdata;
            ref_wr[sel]++;
        end else begin
            exp_data = ref_mem[sel][addr];
            ref_rd[sel]++;
        end
        if (rr !== 1'b1) failures++;
        @(posedge clk);
        #1;
        if (!hold) drive(sel, 1'b0, 1'b0, 5'($urandom), 3'($urandom));
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            sample(sel, rv, rr, rd, rc, wc);
            checks++;
            if (rv !== 1'(k == lat)) begin
                failures++;
                $display("FAIL %s resp_valid cycle=%0d got=%b exp=%b", tag, k, rv, (k == lat));
            end
            checks++;
            if (rr !== 1'(k == lat + 1)) begin
                failures++;
                $display("FAIL %s req_ready cycle=%0d got=%b exp=%b", tag, k, rr, (k == lat + 1));
            end
            if (k == lat) begin
                checks++;
                if (rd !== exp_data) begin
                    failures++;
                    $display("FAIL %s resp_rdata got=%b exp=%b", tag, rd, exp_data);
                end
            end
            if (k == lat + 1) begin
                checks++;
                if (rc !== exp_cnt(ref_rd[sel]) || wc !== exp_cnt(ref_wr[sel])) begin
                    failures++;
                    $display("FAIL %s counters got rd=%0d wr=%0d exp rd=%0d wr=%0d",
                             tag, rc, wc, exp_cnt(ref_rd[sel]), exp_cnt(ref_wr[sel]));
                end
                drive(sel, 1'b0, 1'b0, 5'($urandom), 3'($urandom));
            end else if (hold) begin
                drive(sel, 1'b1, 1'($urandom), 5'($urandom), 3'($urandom));
            end
        end
        $display("txn %s dut=%0d %s addr=%b wdata=%b rdata=%b rd=%0d wr=%0d",
                 tag, sel, wr ? "W" : "R", addr, wdata, exp_data, rc, wc);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (a_req_ready !== 1'b1 || a_resp_valid !== 1'b0 || a_resp_rdata !== 3'b000) begin
            failures++;
            $display("FAIL reset_a got ready=%b valid=%b rdata=%b exp 1 0 000",
                     a_req_ready, a_resp_valid, a_resp_rdata);
        end
        checks++;
        if (b_req_ready !== 1'b1 || b_resp_valid !== 1'b0 || b_resp_rdata !== 3'b000) begin
            failures++;
            $display("FAIL reset_b got ready=%b valid=%b rdata=%b exp 1 0 000",
                     b_req_ready, b_resp_valid, b_resp_rdata);
        end
        checks++;
        if (a_rd_count !== 8'd0 || a_wr_count !== 8'd0 || b_rd_count !== 8'd0 || b_wr_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_counters got a=%0d/%0d b=%0d/%0d exp 0", a_rd_count, a_wr_count,
                     b_rd_count, b_wr_count);
        end
        $display("txn reset");
    endtask

    task automatic test_first_read();
        txn(0, 1'b0, 5'b10110, 3'b000, 1'b0, "first_read");
    endtask

    task automatic test_write_read();
        txn(0, 1'b1, 5'b01011, 3'b101, 1'b0, "wb_write");
        txn(0, 1'b0, 5'b01011, 3'b000, 1'b0, "wb_readback");
    endtask

    task automatic test_hold();
        txn(0, 1'b0, 5'($urandom), 3'b000, 1'b1, "hold_read");
        txn(0, 1'b1, 5'($urandom), 3'($urandom), 1'b1, "hold_write");
    endtask

    task automatic test_latency_one();
        logic [4:0] addr;
        addr = 5'($urandom);
        txn(1, 1'b0, addr, 3'b000, 1'b0, "lat1_read");
        txn(1, 1'b1, addr, 3'($urandom), 1'b0, "lat1_write");
        txn(1, 1'b0, addr, 3'b000, 1'b1, "lat1_readback");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            txn($urandom_range(0, 1), 1'($urandom), 5'($urandom), 3'($urandom),
                1'($urandom), "random");
        end
    endtask

    task automatic test_reset_mid_write();
        drive(0, 1'b1, 1'b1, 5'd3, 3'b000);
        @(posedge clk);
        #1 drive(0, 1'b0, 1'b0, 5'd0, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        $display("txn reset_mid_write dut=0 W addr=00011 aborted");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (a_resp_valid !== 1'b0) begin
                failures++;
                $display("FAIL abort_resp_valid cycle=%0d got=%b exp=0", k, a_resp_valid);
            end
        end
        checks++;
        if (a_req_ready !== 1'b1 || a_rd_count !== 8'd0 || a_wr_count !== 8'd0) begin
            failures++;
            $display("FAIL abort_state got ready=%b rd=%0d wr=%0d exp 1 0 0",
                     a_req_ready, a_rd_count, a_wr_count);
        end
        txn(0, 1'b0, 5'd3, 3'b000, 1'b0, "read_after_abort");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            txn(0, 1'b0, 5'($urandom), 3'b000, 1'b0, "b2b_read");
        end
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_write_read();
        test_hold();
        test_latency_one();
        test_random();
        test_reset_mid_write();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
